// File: rtl/axi_burst_ram_if.sv
// AXI4 bundle used between the burst adapter and the RAM model.
// Only the signals the memory model consumes or drives are carried.
interface axi_interface_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) ();
  // Read address / read data
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  // Write address / write data / write response
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;

  modport rd_slv (
    input  arvalid, arid, araddr, arlen, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );

  modport wr_slv (
    input  awvalid, awid, awaddr, awlen, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bid, bresp
  );
endinterface

// File: rtl/axi_burst_ram.sv
// AXI4 slave memory model: one INCR read or write burst at a time out of a
// word array, with a programmable delay before the first read beat.
module axi_burst_ram #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 4,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  axi_interface_if.rd_slv axi_read_in,
  axi_interface_if.wr_slv axi_write_in
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;

  // Address bits outside the word index are aliased away on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_read_in.araddr[ADDR_W-1:IDX_W+3], axi_read_in.araddr[2:0],
                              axi_write_in.awaddr[ADDR_W-1:IDX_W+3], axi_write_in.awaddr[2:0]};

  // Handshake readies follow the state directly so the first idle cycle after
  // reset release already offers awready.
  assign axi_write_in.awready = rst_n && (state_q == IDLE);
  assign axi_read_in.arready  = rst_n && (state_q == IDLE) && !axi_write_in.awvalid;

  assign axi_read_in.rvalid  = rvalid_q;
  assign axi_read_in.rlast   = rlast_q;
  assign axi_read_in.rid     = id_q;
  assign axi_read_in.rdata   = mem[idx_q];
  assign axi_read_in.rresp   = 2'b00;
  assign axi_write_in.wready = wready_q;
  assign axi_write_in.bvalid = bvalid_q;
  assign axi_write_in.bid    = id_q;
  assign axi_write_in.bresp  = 2'b00;

  assign mem_we = (state_q == WR_DATA) && axi_write_in.wvalid;

  // Next-state and next-output decode for the burst sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    beat_d   = beat_q;
    len_d    = len_q;
    id_d     = id_q;
    lat_d    = lat_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    wready_d = wready_q;
    bvalid_d = bvalid_q;
    unique case (state_q)
      IDLE: begin
        if (axi_write_in.awvalid) begin
          id_d     = axi_write_in.awid;
          idx_d    = axi_write_in.awaddr[IDX_W+2:3];
          len_d    = axi_write_in.awlen;
          beat_d   = '0;
          wready_d = 1'b1;
          state_d  = WR_DATA;
        end else if (axi_read_in.arvalid) begin
          id_d   = axi_read_in.arid;
          idx_d  = axi_read_in.araddr[IDX_W+2:3];
          len_d  = axi_read_in.arlen;
          beat_d = '0;
          if (RD_LATENCY > 0) begin
            lat_d   = LAT_LOAD;
            state_d = RD_WAIT;
          end else begin
            rvalid_d = 1'b1;
            rlast_d  = (axi_read_in.arlen == 8'd0);
            state_d  = RD_DATA;
          end
        end
      end
      RD_WAIT: begin
        if (lat_q == '0) begin
          rvalid_d = 1'b1;
          rlast_d  = (len_q == 8'd0);
          state_d  = RD_DATA;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RD_DATA: begin
        if (axi_read_in.rready) begin
          if (beat_q == len_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            beat_d  = beat_q + 8'd1;
            rlast_d = ((beat_q + 8'd1) == len_q);
          end
        end
      end
      WR_DATA: begin
        if (axi_write_in.wvalid) begin
          if (beat_q == len_q) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            state_d  = WR_RESP;
          end else begin
            idx_d  = idx_q + 1'b1;
            beat_d = beat_q + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (axi_write_in.bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered handshake outputs; reset abandons any burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      id_q     <= id_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      wready_q <= wready_d;
      bvalid_q <= bvalid_d;
    end
  end

  // Byte-lane merge into the word array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (axi_write_in.wstrb[i]) mem[idx_q][i*8 +: 8] <= axi_write_in.wdata[i*8 +: 8];
      end
    end
  end
endmodule
